// File: rtl/rs_issue_scheduler.sv
// Unified reservation station: two-wide dispatch, three wakeup buses, and
// oldest-ready-first selection onto registered alu1/alu2/mem issue ports.
module rs_issue_scheduler #(
  parameter int RS_DEPTH  = 16,
  parameter int PAYLOAD_W = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 disp_valid_a,
  input  logic                 disp_valid_b,
  input  logic [1:0]           disp_fu_a,
  input  logic [1:0]           disp_fu_b,
  input  logic [3:0]           disp_rob_a,
  input  logic [3:0]           disp_rob_b,
  input  logic [5:0]           disp_rs1_a,
  input  logic [5:0]           disp_rs1_b,
  input  logic [5:0]           disp_rs2_a,
  input  logic [5:0]           disp_rs2_b,
  input  logic [5:0]           disp_rd_a,
  input  logic [5:0]           disp_rd_b,
  input  logic                 disp_src1rdy_a,
  input  logic                 disp_src1rdy_b,
  input  logic                 disp_src2rdy_a,
  input  logic                 disp_src2rdy_b,
  input  logic [PAYLOAD_W-1:0] disp_payload_a,
  input  logic [PAYLOAD_W-1:0] disp_payload_b,
  input  logic [2:0]           wake_valid,
  input  logic [17:0]          wake_tag,
  input  logic                 fu_rdy_alu1,
  input  logic                 fu_rdy_alu2,
  input  logic                 fu_rdy_mem,
  input  logic [3:0]           rob_head,
  input  logic                 flush,
  output logic                 rs_full,
  output logic                 iss_valid_alu1,
  output logic                 iss_valid_alu2,
  output logic                 iss_valid_mem,
  output logic [3:0]           iss_rob_alu1,
  output logic [3:0]           iss_rob_alu2,
  output logic [3:0]           iss_rob_mem,
  output logic [5:0]           iss_rs1_alu1,
  output logic [5:0]           iss_rs1_alu2,
  output logic [5:0]           iss_rs1_mem,
  output logic [5:0]           iss_rs2_alu1,
  output logic [5:0]           iss_rs2_alu2,
  output logic [5:0]           iss_rs2_mem,
  output logic [5:0]           iss_rd_alu1,
  output logic [5:0]           iss_rd_alu2,
  output logic [5:0]           iss_rd_mem,
  output logic [PAYLOAD_W-1:0] iss_payload_alu1,
  output logic [PAYLOAD_W-1:0] iss_payload_alu2,
  output logic [PAYLOAD_W-1:0] iss_payload_mem
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic                 ent_valid_q   [RS_DEPTH];
  logic                 ent_src1rdy_q [RS_DEPTH];
  logic                 ent_src2rdy_q [RS_DEPTH];
  logic                 ent_valid_d   [RS_DEPTH];
  logic                 ent_src1rdy_d [RS_DEPTH];
  logic                 ent_src2rdy_d [RS_DEPTH];
  logic                 ent_mem_q     [RS_DEPTH];
  logic [3:0]           ent_rob_q     [RS_DEPTH];
  logic [5:0]           ent_rs1_q     [RS_DEPTH];
  logic [5:0]           ent_rs2_q     [RS_DEPTH];
  logic [5:0]           ent_rd_q      [RS_DEPTH];
  logic [PAYLOAD_W-1:0] ent_payload_q [RS_DEPTH];

  logic [RS_DEPTH-1:0] ent_rdy, iss_mask;
  logic [IDX_W-1:0]    a_idx, b_idx, r0_idx, r1_idx, m_idx, alu2_idx;
  logic                a_found, b_found, r0_found, r1_found, m_found;
  logic                alloc_a, alloc_b, do_alu1, do_alu2, do_mem;
  logic [CNT_W-1:0]    vcnt;

  function automatic logic woken(input logic [5:0] tag, input logic [2:0] wv,
                                 input logic [17:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++)
      if (wv[k] && wt[k*6 +: 6] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Allocation and occupancy look only at registered valid bits, so an entry
  // freed by this cycle's issue is not handed out until next cycle.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    vcnt    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      vcnt = vcnt + CNT_W'(ent_valid_q[i]);
      if (!ent_valid_q[i]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = IDX_W'(i);
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign rs_full = (vcnt > CNT_W'(RS_DEPTH - 2));
  assign alloc_a = disp_valid_a & a_found & ~flush;
  assign alloc_b = disp_valid_a & disp_valid_b & b_found & ~flush;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++)
      ent_rdy[i] = ent_valid_q[i] & ent_src1rdy_q[i] & ent_src2rdy_q[i];
  end

  always_comb begin
    logic [3:0] age_i;
    logic [3:0] r0_age, r1_age, m_age;
    age_i    = '0;
    r0_found = 1'b0;
    r1_found = 1'b0;
    m_found  = 1'b0;
    r0_idx   = '0;
    r1_idx   = '0;
    m_idx    = '0;
    r0_age   = '0;
    r1_age   = '0;
    m_age    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      age_i = ent_rob_q[i] - rob_head;
      if (ent_rdy[i] && !ent_mem_q[i] && (!r0_found || age_i < r0_age)) begin
        r0_found = 1'b1;
        r0_idx   = IDX_W'(i);
        r0_age   = age_i;
      end
      if (ent_rdy[i] && ent_mem_q[i] && (!m_found || age_i < m_age)) begin
        m_found = 1'b1;
        m_idx   = IDX_W'(i);
        m_age   = age_i;
      end
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      age_i = ent_rob_q[i] - rob_head;
      if (ent_rdy[i] && !ent_mem_q[i] && IDX_W'(i) != r0_idx &&
          (!r1_found || age_i < r1_age)) begin
        r1_found = 1'b1;
        r1_idx   = IDX_W'(i);
        r1_age   = age_i;
      end
    end
  end

  // alu2 takes the second-oldest when alu1 is taking the oldest, else the oldest.
  assign do_alu1  = fu_rdy_alu1 & r0_found & ~flush;
  assign do_alu2  = fu_rdy_alu2 & (fu_rdy_alu1 ? r1_found : r0_found) & ~flush;
  assign alu2_idx = fu_rdy_alu1 ? r1_idx : r0_idx;
  assign do_mem   = fu_rdy_mem & m_found & ~flush;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++)
      iss_mask[i] = (do_alu1 && r0_idx == IDX_W'(i)) ||
                    (do_alu2 && alu2_idx == IDX_W'(i)) ||
                    (do_mem && m_idx == IDX_W'(i));
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_valid_d[i]   = ent_valid_q[i] & ~iss_mask[i];
      ent_src1rdy_d[i] = ent_src1rdy_q[i] | woken(ent_rs1_q[i], wake_valid, wake_tag);
      ent_src2rdy_d[i] = ent_src2rdy_q[i] | woken(ent_rs2_q[i], wake_valid, wake_tag);
      if (alloc_a && a_idx == IDX_W'(i)) begin
        ent_valid_d[i]   = 1'b1;
        ent_src1rdy_d[i] = disp_src1rdy_a | (disp_rs1_a == 6'd0) |
                           woken(disp_rs1_a, wake_valid, wake_tag);
        ent_src2rdy_d[i] = disp_src2rdy_a | (disp_rs2_a == 6'd0) |
                           woken(disp_rs2_a, wake_valid, wake_tag);
      end else if (alloc_b && b_idx == IDX_W'(i)) begin
        ent_valid_d[i]   = 1'b1;
        ent_src1rdy_d[i] = disp_src1rdy_b | (disp_rs1_b == 6'd0) |
                           woken(disp_rs1_b, wake_valid, wake_tag);
        ent_src2rdy_d[i] = disp_src2rdy_b | (disp_rs2_b == 6'd0) |
                           woken(disp_rs2_b, wake_valid, wake_tag);
      end
      if (flush) ent_valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_valid_q[i]   <= 1'b0;
        ent_src1rdy_q[i] <= 1'b0;
        ent_src2rdy_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_valid_q[i]   <= ent_valid_d[i];
        ent_src1rdy_q[i] <= ent_src1rdy_d[i];
        ent_src2rdy_q[i] <= ent_src2rdy_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (alloc_a && a_idx == IDX_W'(i)) begin
        ent_mem_q[i]     <= (disp_fu_a == 2'd2);
        ent_rob_q[i]     <= disp_rob_a;
        ent_rs1_q[i]     <= disp_rs1_a;
        ent_rs2_q[i]     <= disp_rs2_a;
        ent_rd_q[i]      <= disp_rd_a;
        ent_payload_q[i] <= disp_payload_a;
      end else if (alloc_b && b_idx == IDX_W'(i)) begin
        ent_mem_q[i]     <= (disp_fu_b == 2'd2);
        ent_rob_q[i]     <= disp_rob_b;
        ent_rs1_q[i]     <= disp_rs1_b;
        ent_rs2_q[i]     <= disp_rs2_b;
        ent_rd_q[i]      <= disp_rd_b;
        ent_payload_q[i] <= disp_payload_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid_alu1 <= 1'b0;
      iss_valid_alu2 <= 1'b0;
      iss_valid_mem  <= 1'b0;
      iss_rob_alu1 <= '0; iss_rs1_alu1 <= '0; iss_rs2_alu1 <= '0; iss_rd_alu1 <= '0;
      iss_rob_alu2 <= '0; iss_rs1_alu2 <= '0; iss_rs2_alu2 <= '0; iss_rd_alu2 <= '0;
      iss_rob_mem  <= '0; iss_rs1_mem  <= '0; iss_rs2_mem  <= '0; iss_rd_mem  <= '0;
      iss_payload_alu1 <= '0;
      iss_payload_alu2 <= '0;
      iss_payload_mem  <= '0;
    end else begin
      iss_valid_alu1 <= do_alu1;
      iss_valid_alu2 <= do_alu2;
      iss_valid_mem  <= do_mem;
      if (do_alu1) begin
        iss_rob_alu1     <= ent_rob_q[r0_idx];
        iss_rs1_alu1     <= ent_rs1_q[r0_idx];
        iss_rs2_alu1     <= ent_rs2_q[r0_idx];
        iss_rd_alu1      <= ent_rd_q[r0_idx];
        iss_payload_alu1 <= ent_payload_q[r0_idx];
      end
      if (do_alu2) begin
        iss_rob_alu2     <= ent_rob_q[alu2_idx];
        iss_rs1_alu2     <= ent_rs1_q[alu2_idx];
        iss_rs2_alu2     <= ent_rs2_q[alu2_idx];
        iss_rd_alu2      <= ent_rd_q[alu2_idx];
        iss_payload_alu2 <= ent_payload_q[alu2_idx];
      end
      if (do_mem) begin
        iss_rob_mem     <= ent_rob_q[m_idx];
        iss_rs1_mem     <= ent_rs1_q[m_idx];
        iss_rs2_mem     <= ent_rs2_q[m_idx];
        iss_rd_mem      <= ent_rd_q[m_idx];
        iss_payload_mem <= ent_payload_q[m_idx];
      end
    end
  end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: stimulus pushes expected issues and
// state checks into queues; a negedge monitor pops and compares them.
module tb_rs_issue_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid_a, disp_valid_b;
  logic [1:0]  disp_fu_a, disp_fu_b;
  logic [3:0]  disp_rob_a, disp_rob_b;
  logic [5:0]  disp_rs1_a, disp_rs1_b, disp_rs2_a, disp_rs2_b, disp_rd_a, disp_rd_b;
  logic        disp_src1rdy_a, disp_src1rdy_b, disp_src2rdy_a, disp_src2rdy_b;
  logic [79:0] disp_payload_a, disp_payload_b;
  logic [2:0]  wake_valid;
  logic [17:0] wake_tag;
  logic        fu_rdy_alu1, fu_rdy_alu2, fu_rdy_mem;
  logic [3:0]  rob_head;
  logic        flush;
  logic        rs_full;
  logic        iss_valid_alu1, iss_valid_alu2, iss_valid_mem;
  logic [3:0]  iss_rob_alu1, iss_rob_alu2, iss_rob_mem;
  logic [5:0]  iss_rs1_alu1, iss_rs1_alu2, iss_rs1_mem;
  logic [5:0]  iss_rs2_alu1, iss_rs2_alu2, iss_rs2_mem;
  logic [5:0]  iss_rd_alu1, iss_rd_alu2, iss_rd_mem;
  logic [79:0] iss_payload_alu1, iss_payload_alu2, iss_payload_mem;

  rs_issue_scheduler #(.RS_DEPTH(16), .PAYLOAD_W(80)) dut (
    .clk(clk), .reset(reset),
    .disp_valid_a(disp_valid_a), .disp_valid_b(disp_valid_b),
    .disp_fu_a(disp_fu_a), .disp_fu_b(disp_fu_b),
    .disp_rob_a(disp_rob_a), .disp_rob_b(disp_rob_b),
    .disp_rs1_a(disp_rs1_a), .disp_rs1_b(disp_rs1_b),
    .disp_rs2_a(disp_rs2_a), .disp_rs2_b(disp_rs2_b),
    .disp_rd_a(disp_rd_a), .disp_rd_b(disp_rd_b),
    .disp_src1rdy_a(disp_src1rdy_a), .disp_src1rdy_b(disp_src1rdy_b),
    .disp_src2rdy_a(disp_src2rdy_a), .disp_src2rdy_b(disp_src2rdy_b),
    .disp_payload_a(disp_payload_a), .disp_payload_b(disp_payload_b),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .fu_rdy_alu1(fu_rdy_alu1), .fu_rdy_alu2(fu_rdy_alu2), .fu_rdy_mem(fu_rdy_mem),
    .rob_head(rob_head), .flush(flush), .rs_full(rs_full),
    .iss_valid_alu1(iss_valid_alu1), .iss_valid_alu2(iss_valid_alu2),
    .iss_valid_mem(iss_valid_mem),
    .iss_rob_alu1(iss_rob_alu1), .iss_rob_alu2(iss_rob_alu2), .iss_rob_mem(iss_rob_mem),
    .iss_rs1_alu1(iss_rs1_alu1), .iss_rs1_alu2(iss_rs1_alu2), .iss_rs1_mem(iss_rs1_mem),
    .iss_rs2_alu1(iss_rs2_alu1), .iss_rs2_alu2(iss_rs2_alu2), .iss_rs2_mem(iss_rs2_mem),
    .iss_rd_alu1(iss_rd_alu1), .iss_rd_alu2(iss_rd_alu2), .iss_rd_mem(iss_rd_mem),
    .iss_payload_alu1(iss_payload_alu1), .iss_payload_alu2(iss_payload_alu2),
    .iss_payload_mem(iss_payload_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] rob;
    logic [5:0] rs1;
    logic [5:0] rs2;
  } iss_exp_t;

  typedef struct {
    int cyc;
    bit full;
    bit idle;
  } st_exp_t;

  iss_exp_t q_alu1[$], q_alu2[$], q_mem[$];
  st_exp_t  q_st[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0]  t1(input logic [3:0] r);  return {2'b01, r}; endfunction
  function automatic logic [5:0]  t2(input logic [3:0] r);  return {2'b10, r}; endfunction
  function automatic logic [5:0]  trd(input logic [3:0] r); return {2'b11, r}; endfunction
  function automatic logic [79:0] pl_of(input logic [3:0] r); return {16{r, 1'b1}}; endfunction

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_iss(input int fu, input logic [3:0] rob, input logic [5:0] rs1,
                           input logic [5:0] rs2, input logic [5:0] rd, input logic [79:0] pl);
    iss_exp_t e;
    bit empty;
    empty = 1'b0;
    e = '{cyc: 0, rob: 4'd0, rs1: 6'd0, rs2: 6'd0};
    case (fu)
      0: if (q_alu1.size() == 0) empty = 1'b1; else e = q_alu1.pop_front();
      1: if (q_alu2.size() == 0) empty = 1'b1; else e = q_alu2.pop_front();
      default: if (q_mem.size() == 0) empty = 1'b1; else e = q_mem.pop_front();
    endcase
    if (empty) begin
      total++;
      bad++;
      $display("FAIL unexpected_issue fu=%0d at cycle %0d: got rob %0d expected no issue",
               fu, cyc, rob);
    end else begin
      cmp($sformatf("issue_cycle fu%0d rob%0d", fu, e.rob), 80'(cyc), 80'(e.cyc));
      cmp($sformatf("issue_rob fu%0d", fu), 80'(rob), 80'(e.rob));
      cmp($sformatf("issue_tags fu%0d", fu), 80'({rs1, rs2, rd}),
          80'({e.rs1, e.rs2, trd(e.rob)}));
      cmp($sformatf("issue_payload fu%0d", fu), pl, pl_of(e.rob));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (iss_valid_alu1) check_iss(0, iss_rob_alu1, iss_rs1_alu1, iss_rs2_alu1, iss_rd_alu1, iss_payload_alu1);
      if (iss_valid_alu2) check_iss(1, iss_rob_alu2, iss_rs1_alu2, iss_rs2_alu2, iss_rd_alu2, iss_payload_alu2);
      if (iss_valid_mem)  check_iss(2, iss_rob_mem,  iss_rs1_mem,  iss_rs2_mem,  iss_rd_mem,  iss_payload_mem);
    end
    while (q_st.size() != 0 && q_st[0].cyc <= cyc) begin
      st_exp_t s;
      s = q_st.pop_front();
      cmp($sformatf("rs_full@%0d", s.cyc), 80'(rs_full), 80'(s.full));
      if (s.idle)
        cmp($sformatf("iss_idle@%0d", s.cyc),
            80'({iss_valid_alu1, iss_valid_alu2, iss_valid_mem}), 80'(0));
    end
    if (done) begin
      cmp("leftover_alu1", 80'(q_alu1.size()), 80'(0));
      cmp("leftover_alu2", 80'(q_alu2.size()), 80'(0));
      cmp("leftover_mem",  80'(q_mem.size()),  80'(0));
      cmp("leftover_state", 80'(q_st.size()), 80'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_a(input logic [1:0] fu, input logic [3:0] rob, input logic [5:0] s1,
                       input logic [5:0] s2, input logic r1, input logic r2);
    disp_valid_a = 1'b1; disp_fu_a = fu; disp_rob_a = rob;
    disp_rs1_a = s1; disp_rs2_a = s2; disp_rd_a = trd(rob);
    disp_src1rdy_a = r1; disp_src2rdy_a = r2; disp_payload_a = pl_of(rob);
  endtask

  task automatic set_b(input logic [1:0] fu, input logic [3:0] rob, input logic [5:0] s1,
                       input logic [5:0] s2, input logic r1, input logic r2);
    disp_valid_b = 1'b1; disp_fu_b = fu; disp_rob_b = rob;
    disp_rs1_b = s1; disp_rs2_b = s2; disp_rd_b = trd(rob);
    disp_src1rdy_b = r1; disp_src2rdy_b = r2; disp_payload_b = pl_of(rob);
  endtask

  task automatic clr_disp();
    disp_valid_a = 1'b0;
    disp_valid_b = 1'b0;
  endtask

  task automatic set_rdy(input logic a1, input logic a2, input logic m);
    fu_rdy_alu1 = a1; fu_rdy_alu2 = a2; fu_rdy_mem = m;
  endtask

  task automatic exp_iss(input int fu, input int at, input logic [3:0] rob,
                         input logic [5:0] s1, input logic [5:0] s2);
    iss_exp_t e;
    e = '{cyc: at, rob: rob, rs1: s1, rs2: s2};
    case (fu)
      0: q_alu1.push_back(e);
      1: q_alu2.push_back(e);
      default: q_mem.push_back(e);
    endcase
  endtask

  task automatic exp_st(input int at, input bit full, input bit idle);
    st_exp_t s;
    s = '{cyc: at, full: full, idle: idle};
    q_st.push_back(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; rob_head = 4'd0;
    disp_valid_a = 0; disp_valid_b = 0; disp_fu_a = 0; disp_fu_b = 0;
    disp_rob_a = 0; disp_rob_b = 0; disp_rs1_a = 0; disp_rs1_b = 0;
    disp_rs2_a = 0; disp_rs2_b = 0; disp_rd_a = 0; disp_rd_b = 0;
    disp_src1rdy_a = 0; disp_src1rdy_b = 0; disp_src2rdy_a = 0; disp_src2rdy_b = 0;
    disp_payload_a = '0; disp_payload_b = '0;
    wake_valid = 3'b000; wake_tag = '0;
    set_rdy(1, 1, 1);

    tick();
    exp_st(cyc, 0, 1);
    tick();
    reset = 1'b0;
    ticks(2);

    // single ready ALU op issues one cycle after its dispatch edge
    set_a(2'd0, 4'd3, t1(3), t2(3), 1, 1);
    exp_iss(0, cyc + 2, 4'd3, t1(3), t2(3));
    tick(); clr_disp();
    exp_st(cyc, 0, 0);
    ticks(3);

    // wakeup on wake bus 1; src2 is x0 and must count as ready
    set_a(2'd0, 4'd5, 6'd12, 6'd0, 0, 0);
    tick(); clr_disp();
    tick();
    wake_valid = 3'b010; wake_tag = '0; wake_tag[11:6] = 6'd12;
    tick();
    wake_valid = 3'b000;
    exp_iss(0, cyc + 1, 4'd5, 6'd12, 6'd0);
    ticks(3);

    // same-cycle bypass: dispatch with src1 being woken is stored ready
    set_a(2'd0, 4'd6, 6'd20, 6'd21, 0, 1);
    wake_valid = 3'b001; wake_tag = '0; wake_tag[5:0] = 6'd20;
    exp_iss(0, cyc + 2, 4'd6, 6'd20, 6'd21);
    tick(); clr_disp(); wake_valid = 3'b000;
    ticks(3);

    // three ready ALU ops, both ALUs ready
    rob_head = 4'd6;
    set_rdy(0, 0, 0);
    set_a(2'd0, 4'd7, t1(7), t2(7), 1, 1);
    set_b(2'd0, 4'd8, t1(8), t2(8), 1, 1);
    tick(); clr_disp();
    set_a(2'd0, 4'd9, t1(9), t2(9), 1, 1);
    tick(); clr_disp();
    set_rdy(1, 1, 0);
    exp_iss(0, cyc + 1, 4'd7, t1(7), t2(7));
    exp_iss(1, cyc + 1, 4'd8, t1(8), t2(8));
    exp_iss(0, cyc + 2, 4'd9, t1(9), t2(9));
    ticks(2);
    set_rdy(0, 0, 0);
    ticks(2);

    // same with alu1 busy: oldest goes to alu2, others wait
    set_a(2'd0, 4'd7, t1(7), t2(7), 1, 1);
    set_b(2'd0, 4'd8, t1(8), t2(8), 1, 1);
    tick(); clr_disp();
    set_a(2'd0, 4'd9, t1(9), t2(9), 1, 1);
    tick(); clr_disp();
    set_rdy(0, 1, 0);
    exp_iss(1, cyc + 1, 4'd7, t1(7), t2(7));
    tick();
    set_rdy(0, 0, 0);
    ticks(3);
    set_rdy(1, 1, 0);
    exp_iss(0, cyc + 1, 4'd8, t1(8), t2(8));
    exp_iss(1, cyc + 1, 4'd9, t1(9), t2(9));
    ticks(2);
    set_rdy(0, 0, 0);
    ticks(2);

    // ROB wrap: head 14, rob 15 older than rob 1; held off while mem busy
    rob_head = 4'd14;
    set_a(2'd2, 4'd1, t1(1), t2(1), 1, 1);
    set_b(2'd2, 4'd15, t1(15), t2(15), 1, 1);
    tick(); clr_disp();
    ticks(3);
    set_rdy(0, 0, 1);
    exp_iss(2, cyc + 1, 4'd15, t1(15), t2(15));
    exp_iss(2, cyc + 2, 4'd1, t1(1), t2(1));
    ticks(2);
    set_rdy(0, 0, 0);
    ticks(2);

    // fill to RS_DEPTH-1, then free one by issue
    rob_head = 4'd0;
    for (int k = 0; k < 7; k++) begin
      set_a(2'd0, 4'(2*k),   t1(4'(2*k)),   t2(4'(2*k)),   1, 1);
      set_b(2'd0, 4'(2*k+1), t1(4'(2*k+1)), t2(4'(2*k+1)), 1, 1);
      tick();
    end
    clr_disp();
    exp_st(cyc, 0, 0);
    set_a(2'd0, 4'd14, t1(14), t2(14), 1, 1);
    tick(); clr_disp();
    exp_st(cyc, 1, 0);
    tick();
    set_rdy(1, 0, 0);
    exp_iss(0, cyc + 1, 4'd0, t1(0), t2(0));
    tick();
    set_rdy(0, 0, 0);
    exp_st(cyc, 0, 0);
    tick();

    // flush with ready entries, open FUs and a dispatch in the same cycle
    set_rdy(1, 1, 1);
    flush = 1'b1;
    set_a(2'd0, 4'd15, t1(15), t2(15), 1, 1);
    tick();
    flush = 1'b0; clr_disp();
    exp_st(cyc, 0, 1);
    ticks(4);

    // async reset in mid-operation
    set_rdy(0, 0, 0);
    set_a(2'd0, 4'd0, t1(0), t2(0), 1, 1);
    set_b(2'd0, 4'd1, t1(1), t2(1), 1, 1);
    tick();
    set_a(2'd0, 4'd2, t1(2), t2(2), 1, 1);
    set_b(2'd0, 4'd3, t1(3), t2(3), 1, 1);
    tick(); clr_disp();
    set_rdy(1, 0, 0);
    exp_iss(0, cyc + 1, 4'd0, t1(0), t2(0));
    tick();
    set_rdy(1, 1, 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    set_a(2'd0, 4'd9, t1(9), t2(9), 1, 1);
    exp_st(cyc + 1, 0, 1);
    tick();
    reset = 1'b0; clr_disp();
    exp_st(cyc, 0, 1);
    ticks(4);

    done = 1'b1;
    ticks(3);
    $display("FAIL end_of_test: monitor did not finish");
    $fatal(1);
  end
endmodule
